oka_clmul_seq: RTL
==================

OKA_CLMUL_SEQ -- requirements
Module: oka_clmul_seq

Interface
REQ-001 SHALL provide parameter W, default 8, operand width in bits (W >= 2).
REQ-002 SHALL provide parameter D, default 2, multiplier bits of b consumed per cycle; W % D == 0 SHALL hold, else elaboration error.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operand request valid.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 a  input  W  multiplicand polynomial over GF(2), bit i = coefficient of x^i.
REQ-009 b  input  W  multiplier polynomial over GF(2).
REQ-010 mode  input  1  0 = full carryless product; 1 = product reduced modulo x^W + p.
REQ-011 p  input  W  low coefficients of the reduction polynomial; x^W term implicit.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 y  output  2W-1  result polynomial.

Function
REQ-015 SHALL implement FSM states IDLE, MUL, RED, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 Accept = in_valid & in_ready at a rising edge; a, b, mode, p SHALL be latched then, accumulator cleared, FSM -> MUL; later input changes SHALL be ignored.
REQ-018 MUL SHALL last exactly W/D cycles; step k (k = 0..W/D-1) SHALL XOR (a AND b[k*D+j]) << (k*D+j) into the (2W-1)-bit accumulator for j = 0..D-1. Addition is XOR only, no carries.
REQ-019 After the last MUL step: mode=0 -> DONE; mode=1 -> RED.
REQ-020 RED SHALL last exactly W-1 cycles and process accumulator bit i = 2W-2 down to W, one bit per cycle: if acc[i]=1, acc ^= (p << (i-W)) and acc[i] cleared; if acc[i]=0, no change.
REQ-021 After the last RED step FSM -> DONE; acc[2W-2:W] SHALL then be all zero.
REQ-022 y SHALL equal the accumulator in DONE (mode=1: upper W-1 bits zero) and SHALL hold stable while out_valid=1.
REQ-023 Latency from accept edge to first out_valid=1 cycle: W/D cycles (mode=0), W/D + W-1 cycles (mode=1).
REQ-024 In DONE, out_valid SHALL stay 1 until out_ready=1 at an edge; FSM -> IDLE on that edge; out_ready outside DONE SHALL be ignored.
REQ-025 A new accept SHALL NOT occur in the cycle the result is consumed (in_ready is 0 in DONE); minimum initiation interval = latency + 2 cycles.
REQ-026 y SHALL be 0 whenever the FSM is in IDLE.
REQ-027 Edge cases: a=0 or b=0 -> y=0; p=0 in mode=1 -> y = full product truncated to bits W-1:0.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE, in_ready=1, out_valid=0, y=0, and clear all latched operands, in any state, including mid-MUL/RED and with out_valid pending; the in-flight result SHALL be discarded.
REQ-029 rst SHALL take priority over in_valid and out_ready in the same cycle.

Verification
REQ-030 W=8,D=2, mode=0, a=0x53, b=0xCA -> out_valid 4 cycles after accept, y=0x3F7E.
REQ-031 W=8,D=2, mode=1, p=0x1B, a=0x53, b=0xCA -> out_valid 11 cycles after accept, y=0x0001.
REQ-032 W=8,D=1, mode=0, a=0xFF, b=0xFF -> y=0x5555 after 8 cycles; W=8,D=8 same operands -> y=0x5555 after 1 cycle.
REQ-033 Hold out_ready=0 for 5 cycles in DONE -> out_valid and y stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1, y=0.
REQ-034 Assert rst 2 cycles into MUL -> next cycle in_ready=1, out_valid=0, y=0; a fresh accept then yields the correct result with no residue from the aborted operation.
REQ-035 Random regression, W in {4,8,16}, D dividing W, random mode/p/back-pressure -> y matches a reference carryless multiply-and-reduce model on every out_valid & out_ready handshake.

Source files
------------

// File: rtl/oka_clmul_seq.sv
// oka_clmul_seq: sequential carryless (GF(2)) multiplier with optional
// reduction modulo x^W + p.
//   clk, rst         : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready: operand handshake (a, b, mode, p latched on accept)
//   a, b             : W-bit GF(2) polynomials, bit i = coefficient of x^i
//   mode             : 0 = full (2W-1)-bit product, 1 = reduced mod x^W + p
//   p                : low W coefficients of the reduction polynomial
//   out_valid/out_ready: result handshake, y held stable while out_valid
//   y                : (2W-1)-bit result, zero while idle
module oka_clmul_seq #(
    parameter int unsigned W = 8,
    parameter int unsigned D = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           mode,
    input  logic [W-1:0]   p,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-2:0] y
);

    localparam int unsigned YW    = 2 * W - 1;
    localparam int unsigned STEPS = W / D;
    localparam int unsigned CW    = $clog2(YW + 1);

    if ((W < 2) || (D < 1) || ((W % D) != 0)) begin : g_param_check
        $error("oka_clmul_seq: W must be >= 2 and divisible by D");
    end

    typedef enum logic [1:0] {IDLE, MUL, RED, DONE} state_t;

    state_t          state;
    logic [YW-1:0]   a_sh;     // multiplicand pre-shifted to the current step
    logic [W-1:0]    b_sh;     // multiplier, low D bits are this step's bits
    logic [W-1:0]    p_r;
    logic            mode_r;
    logic [YW-1:0]   acc;
    logic [CW-1:0]   cnt;      // MUL: step index; RED: accumulator bit index

    logic [YW-1:0]   mul_acc;
    logic [YW-1:0]   red_poly;
    logic [YW-1:0]   red_acc;

    // One MUL step: XOR in D shifted copies of a, gated by b bits.
    always_comb begin
        mul_acc = acc;
        for (int j = 0; j < int'(D); j++) begin
            if (b_sh[j]) begin
                mul_acc = mul_acc ^ (a_sh << j);
            end
        end
    end

    // One RED step: (x^W + p) * x^(i-W) has its top term at bit i, so the
    // XOR both folds p in and clears acc[i].
    always_comb begin
        red_poly = YW'({1'b1, p_r}) << (cnt - CW'(W));
        red_acc  = acc[cnt] ? (acc ^ red_poly) : acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            y         <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            p_r       <= '0;
            mode_r    <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= YW'(a);
                        b_sh     <= b;
                        p_r      <= p;
                        mode_r   <= mode;
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= MUL;
                    end
                end
                MUL: begin
                    acc  <= mul_acc;
                    a_sh <= a_sh << D;
                    b_sh <= b_sh >> D;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(STEPS - 1)) begin
                        if (mode_r) begin
                            cnt   <= CW'(YW - 1);
                            state <= RED;
                        end else begin
                            y         <= mul_acc;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                RED: begin
                    acc <= red_acc;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(W)) begin
                        y         <= red_acc;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        y         <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
